// File: rtl/tdm_demux_4ch_pkg.sv
// Shared encodings and sizes for the 4-channel TDM demultiplexer.
package tdm_demux_4ch_pkg;
    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int NCH    = 4;
    localparam int SLOT_W = 2;
endpackage

// File: rtl/tdm_demux_4ch_frame_ctrl.sv
// Framing control: HUNT/LOCKED FSM, slot counter, sticky sync error,
// and decoded shadow write-enables plus a frame commit strobe.
module tdm_frame_ctrl
    import tdm_demux_4ch_pkg::*;
#(
    parameter bit SYNC_EVERY = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_valid,
    input  logic              frame_sync,
    input  logic              err_clr,
    output logic [NCH-2:0]    shadow_we,
    output logic              commit,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err
);
    state_t state;
    logic   is_locked;
    logic   slot_zero;
    logic   err_set;

    assign is_locked = (state == ST_LOCKED);
    assign slot_zero = (slot == '0);
    assign locked    = is_locked;

    // Early sync, or a missing sync on channel 0 when every frame must be marked.
    assign err_set = din_valid && is_locked &&
                     ((frame_sync && !slot_zero) ||
                      (!frame_sync && slot_zero && SYNC_EVERY));

    always_comb begin
        shadow_we    = '0;
        commit       = 1'b0;
        shadow_we[0] = din_valid &&
                       (frame_sync || (is_locked && slot_zero && !SYNC_EVERY));
        if (din_valid && is_locked && !frame_sync) begin
            shadow_we[1] = (slot == SLOT_W'(1));
            shadow_we[2] = (slot == SLOT_W'(2));
            commit       = (slot == SLOT_W'(3));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HUNT;
            slot     <= '0;
            sync_err <= 1'b0;
        end else begin
            if (err_set)
                sync_err <= 1'b1;
            else if (err_clr)
                sync_err <= 1'b0;

            if (din_valid) begin
                case (state)
                    ST_HUNT: begin
                        if (frame_sync) begin
                            state <= ST_LOCKED;
                            slot  <= SLOT_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (frame_sync)
                            slot <= SLOT_W'(1);
                        else if (slot_zero) begin
                            if (SYNC_EVERY)
                                state <= ST_HUNT;
                            else
                                slot <= SLOT_W'(1);
                        end else
                            slot <= slot + SLOT_W'(1);  // 3 -> 0 on frame completion
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end
endmodule

// File: rtl/tdm_demux_4ch.sv
// Receive side of a 4:1 TDM link: collects one frame into shadow registers
// and publishes all four lanes together with a one-cycle frame_valid pulse.
module tdm_demux_4ch
    import tdm_demux_4ch_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter bit SYNC_EVERY = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  din,
    input  logic              din_valid,
    input  logic              frame_sync,
    input  logic              err_clr,
    output logic [WIDTH-1:0]  y0,
    output logic [WIDTH-1:0]  y1,
    output logic [WIDTH-1:0]  y2,
    output logic [WIDTH-1:0]  y3,
    output logic              frame_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err
);
    logic [NCH-2:0]            shadow_we;
    logic                      commit;
    logic [NCH-2:0][WIDTH-1:0] shadow;

    tdm_frame_ctrl #(.SYNC_EVERY(SYNC_EVERY)) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .err_clr    (err_clr),
        .shadow_we  (shadow_we),
        .commit     (commit),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    // Channel 3 goes straight to its lane, so only channels 0..2 need shadows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            y0          <= '0;
            y1          <= '0;
            y2          <= '0;
            y3          <= '0;
            frame_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NCH - 1; i++)
                if (shadow_we[i])
                    shadow[i] <= din;
            frame_valid <= commit;
            if (commit) begin
                y0 <= shadow[0];
                y1 <= shadow[1];
                y2 <= shadow[2];
                y3 <= din;
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch (WIDTH=1, SYNC_EVERY=1).
module tb_tdm_demux_4ch;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic       err_clr;
    logic [0:0] y0, y1, y2, y3;
    logic       frame_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;
    logic [3:0] yv;

    int total = 0;
    int bad   = 0;

    assign yv = {y3, y2, y1, y0};

    tdm_demux_4ch #(.WIDTH(1), .SYNC_EVERY(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .err_clr     (err_clr),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted beat; outputs are sampled 1 time unit after the edge.
    task automatic beat(input logic d, input logic s, input logic c = 1'b0);
        @(negedge clk);
        din = d; din_valid = 1'b1; frame_sync = s; err_clr = c;
        @(posedge clk);
        #1;
        din_valid = 1'b0; frame_sync = 1'b0; err_clr = 1'b0;
    endtask

    task automatic idle(input logic c = 1'b0);
        @(negedge clk);
        err_clr = c;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_y", 8'(yv), 8'h0);
        chk("rst_fv", 8'(frame_valid), 8'h0);
        chk("rst_locked", 8'(locked), 8'h0);
        chk("rst_slot", 8'(slot), 8'h0);
        chk("rst_err", 8'(sync_err), 8'h0);
        rst_n = 1'b1;

        // 1. lock and one frame: 0,1,0,1
        beat(1'b0, 1'b1);
        chk("t1_locked", 8'(locked), 8'h1);
        chk("t1_slot1", 8'(slot), 8'h1);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        chk("t1_slot3", 8'(slot), 8'h3);
        chk("t1_fv_pre", 8'(frame_valid), 8'h0);
        beat(1'b1, 1'b0);
        chk("t1_fv", 8'(frame_valid), 8'h1);
        chk("t1_y", 8'(yv), 8'b1010);
        chk("t1_slot0", 8'(slot), 8'h0);
        chk("t1_locked2", 8'(locked), 8'h1);
        idle();
        chk("t1_fv_drop", 8'(frame_valid), 8'h0);
        chk("t1_y_hold", 8'(yv), 8'b1010);

        // 2. hunt discard
        do_reset();
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 1'b0);
            chk("t2_hunt_locked", 8'(locked), 8'h0);
            chk("t2_hunt_slot", 8'(slot), 8'h0);
        end
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        chk("t2_fv", 8'(frame_valid), 8'h1);
        chk("t2_y", 8'(yv), 8'b1001);
        chk("t2_err", 8'(sync_err), 8'h0);

        // 3. early sync
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b0);
        chk("t3_slot2", 8'(slot), 8'h2);
        beat(1'b0, 1'b1);
        chk("t3_err", 8'(sync_err), 8'h1);
        chk("t3_slot_restart", 8'(slot), 8'h1);
        chk("t3_fv_none", 8'(frame_valid), 8'h0);
        chk("t3_y_hold", 8'(yv), 8'b1001);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        chk("t3_fv_none2", 8'(frame_valid), 8'h0);
        beat(1'b0, 1'b0);
        chk("t3_fv", 8'(frame_valid), 8'h1);
        chk("t3_y", 8'(yv), 8'b0110);

        // 4. missing sync
        idle(1'b1);
        chk("t4_clr", 8'(sync_err), 8'h0);
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        chk("t4_y", 8'(yv), 8'b0011);
        beat(1'b1, 1'b0);
        chk("t4_err", 8'(sync_err), 8'h1);
        chk("t4_locked", 8'(locked), 8'h0);
        chk("t4_slot", 8'(slot), 8'h0);
        chk("t4_y_hold", 8'(yv), 8'b0011);
        chk("t4_fv", 8'(frame_valid), 8'h0);
        idle();
        chk("t4_err_sticky", 8'(sync_err), 8'h1);
        idle(1'b1);
        chk("t4_err_clr", 8'(sync_err), 8'h0);

        // 5. gaps mid-frame, then reset mid-frame
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle();
        chk("t5_gap_slot", 8'(slot), 8'h2);
        chk("t5_gap_fv", 8'(frame_valid), 8'h0);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        chk("t5_fv", 8'(frame_valid), 8'h1);
        chk("t5_y", 8'(yv), 8'b1101);
        beat(1'b0, 1'b1);
        beat(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_y", 8'(yv), 8'h0);
        chk("t5_rst_fv", 8'(frame_valid), 8'h0);
        chk("t5_rst_locked", 8'(locked), 8'h0);
        chk("t5_rst_slot", 8'(slot), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(1'b1, 1'b0);
        chk("t5_relock_needs_sync", 8'(locked), 8'h0);

        // 6. err_clr collides with a new early-sync error
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b1, 1'b1);
        chk("t6_set_wins", 8'(sync_err), 8'h1);
        chk("t6_slot", 8'(slot), 8'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
